// File: rtl/bcd_convert_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// bcd_convert_scheduler_pkg
// Shared definitions for the BCD converter scheduler: FSM state encoding and
// a width helper for index and counter sizing.
// No ports (package).
// ----------------------------------------------------------------------------
package bcd_convert_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // ceil(log2(n)), never less than 1 so single-entry ranges still get a bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_convert_scheduler_rr_arbiter_comb.sv
// ----------------------------------------------------------------------------
// rr_arbiter_comb
// Combinational round-robin picker: returns the first asserted request at or
// after the pointer, wrapping modulo NUM_REQ.
// Ports:
//   i_Req   request vector
//   i_Ptr   round-robin start index (must be < NUM_REQ)
//   o_Valid any request asserted
//   o_Idx   index of the chosen request
// ----------------------------------------------------------------------------
module rr_arbiter_comb
    import bcd_convert_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [IDX_W-1:0]   i_Ptr,
    output logic               o_Valid,
    output logic [IDX_W-1:0]   o_Idx
);

    // One spare bit so ptr + offset cannot overflow before the wrap
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest hit wins last
    always_comb begin
        o_Valid = 1'b0;
        o_Idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_Ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_Req[w_cand]) begin
                o_Valid = 1'b1;
                o_Idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// ----------------------------------------------------------------------------
// bcd_convert_scheduler
// Time-shares one binary-to-BCD converter among NUM_REQ requesters with
// round-robin arbitration, start/data-valid sequencing, per-requester
// done/err pulses and a timeout on a hung converter.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading zero digits of the
// captured result become 4'hF; digit 0 is never blanked).
// Ports:
//   i_Clock, i_Reset_n  clock, asynchronous active-low reset
//   i_Req, i_Binary     level requests and packed operands
//   o_Ack               one-cycle grant pulse (operand sampled)
//   o_Done, o_Err       one-cycle completion / timeout pulses
//   o_BCD               last captured result
//   o_Busy              FSM not idle
//   o_Conv_Binary, o_Conv_Start, i_Conv_BCD, i_Conv_DV  converter interface
// ----------------------------------------------------------------------------
module bcd_convert_scheduler
    import bcd_convert_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned INPUT_WIDTH    = 16,
    parameter int unsigned DECIMAL_DIGITS = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset_n,
    input  logic [NUM_REQ-1:0]              i_Req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  i_Binary,
    output logic [NUM_REQ-1:0]              o_Ack,
    output logic [NUM_REQ-1:0]              o_Done,
    output logic [NUM_REQ-1:0]              o_Err,
    output logic [DECIMAL_DIGITS*4-1:0]     o_BCD,
    output logic                            o_Busy,
    output logic [INPUT_WIDTH-1:0]          o_Conv_Binary,
    output logic                            o_Conv_Start,
    input  logic [DECIMAL_DIGITS*4-1:0]     i_Conv_BCD,
    input  logic                            i_Conv_DV
);

    localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
    localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYCLES);
    localparam int unsigned BCD_W = DECIMAL_DIGITS * 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_e                 r_state, w_state_d;
    logic [IDX_W-1:0]       r_ptr, w_ptr_d;
    logic [IDX_W-1:0]       r_grant, w_grant_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic [NUM_REQ-1:0]     r_ack, w_ack_d;
    logic [NUM_REQ-1:0]     r_done, w_done_d;
    logic [NUM_REQ-1:0]     r_err, w_err_d;
    logic [BCD_W-1:0]       r_bcd, w_bcd_d;
    logic [INPUT_WIDTH-1:0] r_conv_bin, w_conv_bin_d;
    logic                   r_conv_start, w_conv_start_d;

    logic                   w_valid;
    logic [IDX_W-1:0]       w_idx;
    logic [INPUT_WIDTH-1:0] w_operand;
    logic [BCD_W-1:0]       w_bcd_cap;

    rr_arbiter_comb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_Req   (i_Req),
        .i_Ptr   (r_ptr),
        .o_Valid (w_valid),
        .o_Idx   (w_idx)
    );

    always_comb begin
        w_operand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_operand = i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead;

    // Blank zeros from the MS digit down until the first nonzero digit
    always_comb begin
        w_bcd_cap = i_Conv_BCD;
        w_lead    = 1'b1;
        for (int d = DECIMAL_DIGITS - 1; d >= 1; d--) begin
            if (w_lead && (i_Conv_BCD[d*4 +: 4] == 4'd0)) begin
                w_bcd_cap[d*4 +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_bcd_cap = i_Conv_BCD;
`endif

    always_comb begin
        w_state_d      = r_state;
        w_ptr_d        = r_ptr;
        w_grant_d      = r_grant;
        w_cnt_d        = r_cnt;
        w_ack_d        = '0;
        w_done_d       = '0;
        w_err_d        = '0;
        w_bcd_d        = r_bcd;
        w_conv_bin_d   = r_conv_bin;
        w_conv_start_d = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_ack_d[w_idx] = 1'b1;
                    w_conv_bin_d   = w_operand;
                    w_grant_d      = w_idx;
                    w_ptr_d        = (w_idx == IDX_LAST) ? '0 : w_idx + 1'b1;
                    w_state_d      = START;
                end
            end
            START: begin
                w_conv_start_d = 1'b1;
                w_cnt_d        = '0;
                w_state_d      = WAIT;
            end
            WAIT: begin
                if (i_Conv_DV) begin
                    w_bcd_d           = w_bcd_cap;
                    w_done_d[r_grant] = 1'b1;
                    w_state_d         = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_d[r_grant] = 1'b1;
                    w_state_d        = IDLE;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            // Done pulse is already registered on the WAIT->DONE edge
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_ack        <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_bcd        <= '0;
            r_conv_bin   <= '0;
            r_conv_start <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_ptr        <= w_ptr_d;
            r_grant      <= w_grant_d;
            r_cnt        <= w_cnt_d;
            r_ack        <= w_ack_d;
            r_done       <= w_done_d;
            r_err        <= w_err_d;
            r_bcd        <= w_bcd_d;
            r_conv_bin   <= w_conv_bin_d;
            r_conv_start <= w_conv_start_d;
        end
    end

    assign o_Ack         = r_ack;
    assign o_Done        = r_done;
    assign o_Err         = r_err;
    assign o_BCD         = r_bcd;
    assign o_Busy        = (r_state != IDLE);
    assign o_Conv_Binary = r_conv_bin;
    assign o_Conv_Start  = r_conv_start;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// ----------------------------------------------------------------------------
// tb_bcd_convert_scheduler
// Directed-vector bench for bcd_convert_scheduler with a converter model and
// a scoreboard queue checked by an independent monitor process.
// ----------------------------------------------------------------------------
module tb_bcd_convert_scheduler;

    localparam int TMO = 32;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [19:0] B1234  = 20'hF1234;
    localparam logic [19:0] B9     = 20'hFFFF9;
    localparam logic [19:0] B100   = 20'hFF100;
    localparam logic [19:0] B65535 = 20'h65535;
    localparam logic [19:0] B500   = 20'hFF500;
    localparam logic [19:0] B42    = 20'hFFF42;
    localparam logic [19:0] B0     = 20'hFFFF0;
    localparam logic [19:0] B10005 = 20'h10005;
    localparam logic [19:0] B11    = 20'hFFF11;
    localparam logic [19:0] B2024  = 20'hF2024;
`else
    localparam logic [19:0] B1234  = 20'h01234;
    localparam logic [19:0] B9     = 20'h00009;
    localparam logic [19:0] B100   = 20'h00100;
    localparam logic [19:0] B65535 = 20'h65535;
    localparam logic [19:0] B500   = 20'h00500;
    localparam logic [19:0] B42    = 20'h00042;
    localparam logic [19:0] B0     = 20'h00000;
    localparam logic [19:0] B10005 = 20'h10005;
    localparam logic [19:0] B11    = 20'h00011;
    localparam logic [19:0] B2024  = 20'h02024;
`endif

    typedef struct {
        bit          is_err;
        int          idx;
        logic [19:0] bcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] bin;
    logic [3:0]  o_Ack, o_Done, o_Err;
    logic [19:0] o_BCD;
    logic        o_Busy;
    logic [15:0] o_Conv_Binary;
    logic        o_Conv_Start;
    logic [19:0] conv_bcd;
    logic        conv_dv;
    logic        stray;
    logic [19:0] w_conv_bcd;
    logic        w_conv_dv;

    int   cyc = 0;
    int   start_cyc = 0;
    int   dv_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   hang;
    int   lat;
    exp_t exp_q[$];

    assign w_conv_bcd = stray ? 20'h99999 : conv_bcd;
    assign w_conv_dv  = conv_dv | stray;

    bcd_convert_scheduler #(
        .NUM_REQ        (4),
        .INPUT_WIDTH    (16),
        .DECIMAL_DIGITS (5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Req         (req),
        .i_Binary      (bin),
        .o_Ack         (o_Ack),
        .o_Done        (o_Done),
        .o_Err         (o_Err),
        .o_BCD         (o_BCD),
        .o_Busy        (o_Busy),
        .o_Conv_Binary (o_Conv_Binary),
        .o_Conv_Start  (o_Conv_Start),
        .i_Conv_BCD    (w_conv_bcd),
        .i_Conv_DV     (w_conv_dv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic logic [19:0] to_bcd(input logic [15:0] b);
        logic [19:0] r;
        int v;
        v = int'(b);
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Converter model: DV 'lat' cycles after start, or never when hung
    initial begin
        logic [15:0] op;
        bit          pend;
        int          cnt;
        pend = 0; cnt = 0; op = '0;
        conv_dv = 1'b0; conv_bcd = '0;
        forever begin
            @(negedge clk);
            conv_dv = 1'b0;
            if (o_Conv_Start) start_cyc = cyc;
            if (o_Conv_Start && !hang) begin
                pend = 1; op = o_Conv_Binary; cnt = lat - 1;
            end else if (pend) begin
                if (cnt == 0) begin
                    conv_dv = 1'b1; conv_bcd = to_bcd(op); pend = 0; dv_cyc = cyc;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pop and compare on every done/err pulse
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if ((o_Ack | o_Done | o_Err) != 0) begin
                    ok = $onehot0(o_Ack) && $onehot0(o_Done) && $onehot0(o_Err) &&
                         ((int'(o_Ack != 0) + int'(o_Done != 0) + int'(o_Err != 0)) <= 1);
                    check("pulse_exclusive", {31'd0, ok}, 32'd1);
                end
                if ((o_Done | o_Err) != 0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: done=0x%0h err=0x%0h expected none",
                                 o_Done, o_Err);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_err) begin
                            check("err_vec", {28'd0, o_Err}, 32'd1 << e.idx);
                            check("err_latency", cyc - start_cyc, TMO);
                        end else begin
                            check("done_vec", {28'd0, o_Done}, 32'd1 << e.idx);
                            check("done_bcd", {12'd0, o_BCD}, {12'd0, e.bcd});
                            check("done_latency", cyc - dv_cyc, 1);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int idx, input bit is_err, input logic [19:0] bcd);
        exp_t e;
        e.idx = idx; e.is_err = is_err; e.bcd = bcd;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            req = req & ~o_Ack;
            n++;
        end while ((req != 0 || o_Busy || exp_q.size() != 0) && n < 300);
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: got busy/pending after 300 cycles, required idle", name);
        end
    endtask

    task automatic serve(input int idx, input logic [15:0] op, input bit is_err,
                         input logic [19:0] bcd);
        bin[idx*16 +: 16] = op;
        push(idx, is_err, bcd);
        @(negedge clk);
        req[idx] = 1'b1;
        wait_idle("serve");
    endtask

    initial begin
        rst_n = 1'b0; req = '0; bin = '0; hang = 0; lat = 3; stray = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {28'd0, o_Ack}, 0);
        check("rst_done_err", {24'd0, o_Done, o_Err}, 0);
        check("rst_bcd", {12'd0, o_BCD}, 0);
        check("rst_busy_start", {30'd0, o_Busy, o_Conv_Start}, 0);
        check("rst_conv_bin", {16'd0, o_Conv_Binary}, 0);
        rst_n = 1'b1;

        // Single requester 1: ack and start latency
        bin[16 +: 16] = 16'd1234;
        push(1, 0, B1234);
        @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        check("ack_timing", {28'd0, o_Ack}, 32'h2);
        req = req & ~o_Ack;
        @(negedge clk);
        check("start_timing", {31'd0, o_Conv_Start}, 1);
        check("conv_binary", {16'd0, o_Conv_Binary}, 1234);
        check("ack_one_cycle", {28'd0, o_Ack}, 0);
        wait_idle("t1");

        serve(3, 16'd9, 0, B9);   // pointer wraps to 0

        // Simultaneous 0 and 2 from pointer 0, then from pointer 3
        bin[0 +: 16] = 16'd100; bin[32 +: 16] = 16'd65535;
        push(0, 0, B100); push(2, 0, B65535);
        @(negedge clk);
        req = 4'b0101;
        wait_idle("rr1");
        bin[0 +: 16] = 16'd500;
        push(0, 0, B500); push(2, 0, B65535);
        @(negedge clk);
        req = 4'b0101;
        wait_idle("rr2");

        // Hung converter, then normal service
        hang = 1;
        serve(1, 16'd5, 1, '0);
        hang = 0;
        serve(1, 16'd42, 0, B42);

        // Stray DV in IDLE
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_bcd", {12'd0, o_BCD}, {12'd0, B42});
        check("stray_busy", {31'd0, o_Busy}, 0);

        serve(0, 16'd0, 0, B0);
        serve(3, 16'd10005, 0, B10005);

        // Reset mid-WAIT; the late DV must be ignored
        lat = 10;
        bin[32 +: 16] = 16'd777;
        @(negedge clk);
        req[2] = 1'b1;
        @(negedge clk);
        check("rst_test_ack", {28'd0, o_Ack}, 32'h4);
        req = req & ~o_Ack;
        @(negedge clk);
        check("rst_test_start", {31'd0, o_Conv_Start}, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, o_Busy}, 0);
        check("mid_rst_pulses", {20'd0, o_Ack, o_Done, o_Err}, 0);
        check("mid_rst_bcd_bin", {12'd0, o_BCD}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_bcd", {12'd0, o_BCD}, 0);
        check("post_rst_busy", {31'd0, o_Busy}, 0);

        // Pointer back at 0: requester 0 beats 3
        lat = 3;
        bin[0 +: 16] = 16'd11; bin[48 +: 16] = 16'd2024;
        push(0, 0, B11); push(3, 0, B2024);
        @(negedge clk);
        req = 4'b1001;
        wait_idle("ptr_reset");

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_convert_scheduler.md
Name: bcd_convert_scheduler

Overview:
Time-shares one binary-to-BCD converter instance among NUM_REQ requesters, for example the latency min/max/avg/last values feeding the OSD text renderer.
- Round-robin arbitration between requesters.
- Sequences the converter's start/data-valid handshake.
- Routes the captured BCD result back to the winning requester with a per-requester done pulse.
- Guards against a hung converter with a timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INPUT_WIDTH, 16, binary operand width; must match the converter
DECIMAL_DIGITS, 5, BCD digits produced; must match the converter
TIMEOUT_CYCLES, 1023, maximum cycles to wait for converter data-valid before aborting

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous active-low reset
i_Req  in  NUM_REQ  level request per requester, held until o_Ack
i_Binary  in  NUM_REQ*INPUT_WIDTH  operands, requester k at [k*INPUT_WIDTH +: INPUT_WIDTH]
o_Ack  out  NUM_REQ  one-cycle grant pulse; operand sampled on this edge
o_Done  out  NUM_REQ  one-cycle pulse; o_BCD valid for that requester
o_Err  out  NUM_REQ  one-cycle pulse on timeout abort for that requester
o_BCD  out  DECIMAL_DIGITS*4  last result; held until the next done
o_Busy  out  1  high whenever state != IDLE
o_Conv_Binary  out  INPUT_WIDTH  operand to converter
o_Conv_Start  out  1  converter start pulse
i_Conv_BCD  in  DECIMAL_DIGITS*4  converter result
i_Conv_DV  in  1  converter data-valid pulse

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately: no done/err pulse is issued, and a later i_Conv_DV in IDLE is ignored.
- States: IDLE, START, WAIT, DONE.
- IDLE, with any i_Req high:
  - Pick the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - Register o_Ack[w]=1 and o_Conv_Binary=operand[w]; latch grant index w.
  - Set pointer = (w+1) mod NUM_REQ; go to START.
- START: o_Conv_Start=1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - On i_Conv_DV=1: o_BCD <= i_Conv_BCD (or the blanked form, see Optional Feature); go to DONE.
  - Else, if counter == TIMEOUT_CYCLES-1: o_Err[w]=1; go to IDLE.
  - Else increment the counter.
- DONE: o_Done[w]=1 for one cycle; go to IDLE.
- Latency:
  - Request-to-ack: 1 cycle.
  - Ack-to-start: 1 cycle.
  - Done follows DV by 1 cycle.
  - Minimum gap between consecutive starts is 4 cycles plus converter latency.
- Requests:
  - A request dropped before its ack is simply not served.
  - A request held after its ack is re-served on a later turn; requesters must drop i_Req on o_Ack.
  - Simultaneous requests are served in round-robin order; no requester starves (worst-case wait is NUM_REQ-1 conversions).
- i_Conv_DV outside WAIT is ignored.
- o_Ack, o_Done and o_Err are one-hot or zero, and never overlap in the same cycle.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: when capturing the result, each leading zero digit is replaced by 4'hF (the display's blank glyph), scanning from the MS digit down. The scan stops at the first nonzero digit. Digit 0 is never blanked, so value 0 gives 0xFFFF0.
- Undefined: i_Conv_BCD is passed to o_BCD unmodified.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, START=2'd1, WAIT=2'd2, DONE=2'd3.
  - Timeout counter width function (clog2).
- One sub-module, rr_arbiter_comb: combinational round-robin picker that takes request vector + pointer and returns a valid flag + index.
- The blanking logic stays inline under the macro.

Test Plan:
- Single requester 1 with operand 16'd1234 → ack[1] 1 cycle after request, start 1 cycle later, o_Done[1] with o_BCD=20'h01234.
- Requesters 0 and 2 raised together, pointer 0 → served 0 then 2; next simultaneous 0 and 2 → 2 is not first; check o_BCD per done (100→20'h00100, 65535→20'h65535).
- Converter model never asserts DV → o_Err[w] exactly TIMEOUT_CYCLES cycles after start; o_Done stays 0; next request serviced normally.
- Reset asserted mid-WAIT, then DV arrives after release → no o_Done or o_Err; outputs 0; pointer back to 0.
- Stray i_Conv_DV pulse in IDLE → ignored; o_BCD unchanged.
- With LEADING_ZERO_BLANK_EN defined: 42→20'hFFF42, 0→20'hFFFF0, 10005→20'h10005.
